// File: rtl/reflet_float_div_if.sv
// Handshake and operand/result bundle for reflet_float_div.
// The div_zero signal exists only when REFLET_FLOAT_DIV_ZERO_FLAG_EN is defined.
interface reflet_float_div_if #(
    parameter int float_size = 32
);
    logic                  start;
    logic [float_size-1:0] in1;
    logic [float_size-1:0] in2;
    logic                  busy;
    logic                  done;
    logic [float_size-1:0] quot;
`ifdef REFLET_FLOAT_DIV_ZERO_FLAG_EN
    logic                  div_zero;

    modport master (output start, in1, in2, input busy, done, quot, div_zero);
    modport slave  (input start, in1, in2, output busy, done, quot, div_zero);
`else
    modport master (output start, in1, in2, input busy, done, quot);
    modport slave  (input start, in1, in2, output busy, done, quot);
`endif
endinterface

// File: rtl/reflet_float_div.sv
// Sequential float divider: quot = in1 / in2, one restoring quotient bit per
// clock, truncated result, fixed latency of M+3 edges after start.
// Optional divide-by-zero flag output: define REFLET_FLOAT_DIV_ZERO_FLAG_EN.
module reflet_float_div #(
    parameter int float_size = 32
) (
    input  logic               i_clk,
    input  logic               i_reset,   // synchronous, active low
    reflet_float_div_if.slave  bus
);
    // Field widths of the team float format.
    function automatic int exponent_size(input int fs);
        case (fs)
            16:      return 5;
            32:      return 8;
            64:      return 11;
            default: return 8;
        endcase
    endfunction

    function automatic int mantissa_size(input int fs);
        return fs - 1 - exponent_size(fs);
    endfunction

    function automatic int exponent_bias(input int fs);
        return (1 << (exponent_size(fs) - 1)) - 1;
    endfunction

    localparam int E    = exponent_size(float_size);
    localparam int M    = mantissa_size(float_size);
    localparam int BIAS = exponent_bias(float_size);
    localparam int CW   = $clog2(M + 3);

    localparam logic signed [E+1:0] BIAS_S  = (E+2)'(BIAS);
    localparam logic signed [E+1:0] ONE_S   = (E+2)'(1);
    localparam logic        [E:0]   EXP_MAX = {1'b0, {E{1'b1}}};

    typedef enum logic [1:0] {S_IDLE, S_DIVIDE, S_NORM} state_t;

    state_t                  r_state, w_state_nxt;
    logic                    w_load, w_step, w_norm;

    logic [M+1:0]            r_rem;
    logic [M:0]              r_div;
    logic [M+1:0]            r_q;
    logic                    r_sign;
    logic signed [E+1:0]     r_exp;
    logic                    r_zero1, r_zero2;
    logic [CW-1:0]           r_cnt;
    logic                    r_busy, r_done;
    logic [float_size-1:0]   r_quot;
`ifdef REFLET_FLOAT_DIV_ZERO_FLAG_EN
    logic                    r_div_zero;
`endif

    logic                    w_ge;
    logic [M+1:0]            w_rem_sub;
    logic signed [E+1:0]     w_exp_fin;
    logic [M-1:0]            w_mnt;
    logic [float_size-1:0]   w_result;
    logic signed [E+1:0]     w_exp1, w_exp2;

    assign w_exp1 = signed'({2'b00, bus.in1[float_size-2 -: E]});
    assign w_exp2 = signed'({2'b00, bus.in2[float_size-2 -: E]});

    // State register.
    always_ff @(posedge i_clk) begin
        if (!i_reset) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    // Next state and per-state datapath strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_step      = 1'b0;
        w_norm      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_DIVIDE;
                end
            end
            S_DIVIDE: begin
                w_step = 1'b1;
                // Counter value M+1 marks the last of the M+2 steps.
                if (r_cnt == CW'(M + 1)) w_state_nxt = S_NORM;
            end
            S_NORM: begin
                w_norm      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Restoring step: compare the unshifted remainder against the divisor.
    always_comb begin
        w_ge      = (r_rem >= {1'b0, r_div});
        w_rem_sub = w_ge ? (r_rem - {1'b0, r_div}) : r_rem;
    end

    // Normalize the quotient and resolve special cases in priority order.
    always_comb begin
        w_exp_fin = r_q[M+1] ? r_exp : (r_exp - ONE_S);
        w_mnt     = r_q[M+1] ? r_q[M:1] : r_q[M-1:0];
        w_result  = {r_sign, w_exp_fin[E-1:0], w_mnt};
        if (r_zero2)
            w_result = {r_sign, {E{1'b1}}, {M{1'b0}}};
        else if (r_zero1)
            w_result = {r_sign, {(float_size-1){1'b0}}};
        else if (w_exp_fin[E+1] || (w_exp_fin == '0))
            w_result = {r_sign, {(float_size-1){1'b0}}};
        else if (w_exp_fin[E:0] >= EXP_MAX)
            w_result = {r_sign, {E{1'b1}}, {M{1'b0}}};
    end

    // Operand capture, iteration and result registers.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_rem   <= '0;
            r_div   <= '0;
            r_q     <= '0;
            r_sign  <= 1'b0;
            r_exp   <= '0;
            r_zero1 <= 1'b0;
            r_zero2 <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_quot  <= '0;
        end else begin
            r_done <= w_norm;
            if (w_load) begin
                r_rem   <= {1'b0, 1'b1, bus.in1[M-1:0]};
                r_div   <= {1'b1, bus.in2[M-1:0]};
                r_q     <= '0;
                r_sign  <= bus.in1[float_size-1] ^ bus.in2[float_size-1];
                r_exp   <= w_exp1 - w_exp2 + BIAS_S;
                r_zero1 <= (bus.in1[float_size-2:0] == '0);
                r_zero2 <= (bus.in2[float_size-2:0] == '0);
                r_cnt   <= '0;
                r_busy  <= 1'b1;
            end
            if (w_step) begin
                r_rem <= {w_rem_sub[M:0], 1'b0};
                r_q   <= {r_q[M:0], w_ge};
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_norm) begin
                r_quot <= w_result;
                r_busy <= 1'b0;
            end
        end
    end

`ifdef REFLET_FLOAT_DIV_ZERO_FLAG_EN
    // Divide-by-zero flag, updated together with quot.
    always_ff @(posedge i_clk) begin
        if (!i_reset)    r_div_zero <= 1'b0;
        else if (w_norm) r_div_zero <= r_zero2;
    end

    assign bus.div_zero = r_div_zero;
`endif

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.quot = r_quot;
endmodule

// File: tb/tb_reflet_float_div.sv
// Self-checking bench for reflet_float_div (float_size = 32).
module tb_reflet_float_div;
    localparam int FS  = 32;
    localparam int LAT = 26;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    reflet_float_div_if #(.float_size(FS)) bus();
    reflet_float_div #(.float_size(FS)) dut (
        .i_clk   (clk),
        .i_reset (reset),
        .bus     (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Reference: quotient of the significands as exact integer division,
    // then normalization and special-case rules applied to plain numbers.
    function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b);
        logic   s;
        longint sa, sb, q, man;
        int     e;
        s = a[31] ^ b[31];
        if (b[30:0] == 0) return {s, 8'hFF, 23'h0};
        if (a[30:0] == 0) return {s, 31'h0};
        sa = longint'({1'b1, a[22:0]});
        sb = longint'({1'b1, b[22:0]});
        q  = (sa * (longint'(1) << 24)) / sb;
        e  = int'(a[30:23]) - int'(b[30:23]) + 127;
        if (q >= (longint'(1) << 24)) man = q / 2;
        else begin
            man = q;
            e   = e - 1;
        end
        man = man % (longint'(1) << 23);
        if (e <= 0)   return {s, 31'h0};
        if (e >= 255) return {s, 8'hFF, 23'h0};
        return {s, 8'(e), 23'(man)};
    endfunction

    // Caller stands at a falling edge; start is accepted on the next rising edge.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b);
        bus.start = 1'b1;
        bus.in1   = a;
        bus.in2   = b;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Counts rising edges since acceptance until done, bounded.
    task automatic wait_done(input int lat0, output int lat, output bit busy_ok);
        lat     = lat0;
        busy_ok = 1'b1;
        while (bus.done !== 1'b1 && lat < 60) begin
            if (bus.busy !== 1'b1) busy_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        if (bus.busy !== 1'b0) busy_ok = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] q);
        int lat;
        bit bok;
        start_op(a, b);
        wait_done(0, lat, bok);
        chk({tag, " latency"}, 64'(lat), 64'(LAT));
        chk({tag, " busy"}, 64'(bok), 64'd1);
`ifdef REFLET_FLOAT_DIV_ZERO_FLAG_EN
        chk({tag, " div_zero"}, 64'(bus.div_zero), 64'(b[30:0] == 0));
`endif
        q = bus.quot;
    endtask

    initial begin
        logic [31:0] q, a, b;
        int          lat;
        bit          bok, seen;

        bus.start = 1'b0;
        bus.in1   = '0;
        bus.in2   = '0;

        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst busy", 64'(bus.busy), 64'd0);
        chk("rst done", 64'(bus.done), 64'd0);
        chk("rst quot", 64'(bus.quot), 64'd0);
`ifdef REFLET_FLOAT_DIV_ZERO_FLAG_EN
        chk("rst div_zero", 64'(bus.div_zero), 64'd0);
`endif
        reset = 1'b1;
        @(negedge clk);

        // Directed values.
        run_op("6/2", 32'h40C00000, 32'h40000000, q);
        chk("6/2 quot", 64'(q), 64'h40400000);
        @(negedge clk);
        run_op("1/3", 32'h3F800000, 32'h40400000, q);
        chk("1/3 quot", 64'(q), 64'h3EAAAAAA);
        @(negedge clk);
        run_op("-1.5/0.5", 32'hBFC00000, 32'h3F000000, q);
        chk("-1.5/0.5 quot", 64'(q), 64'hC0400000);
        @(negedge clk);
        run_op("0/5", 32'h00000000, 32'h40A00000, q);
        chk("0/5 quot", 64'(q), 64'h00000000);
        @(negedge clk);
        run_op("5/0", 32'h40A00000, 32'h00000000, q);
        chk("5/0 quot", 64'(q), 64'h7F800000);
        @(negedge clk);
        run_op("0/0", 32'h80000000, 32'h00000000, q);
        chk("0/0 quot", 64'(q), 64'hFF800000);
        @(negedge clk);
        run_op("tiny", 32'h00800000, 32'h7F000000, q);
        chk("underflow quot", 64'(q), 64'h00000000);
        @(negedge clk);
        run_op("huge", 32'h7F000000, 32'h00800000, q);
        chk("overflow quot", 64'(q), 64'h7F800000);

        // Start during busy is ignored; operands are not re-sampled.
        @(negedge clk);
        start_op(32'h40C00000, 32'h40000000);
        repeat (4) @(negedge clk);
        bus.start = 1'b1;
        bus.in1   = 32'h3F800000;
        bus.in2   = 32'h40400000;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(5, lat, bok);
        chk("ignored start latency", 64'(lat), 64'(LAT));
        chk("ignored start quot", 64'(bus.quot), 64'h40400000);

        // Start in the done cycle is accepted immediately.
        run_op("b2b", 32'h3F800000, 32'h40400000, q);
        chk("b2b quot", 64'(q), 64'h3EAAAAAA);

        // Reset mid-operation aborts without a done pulse.
        @(negedge clk);
        start_op(32'hBFC00000, 32'h3F000000);
        repeat (9) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("abort busy", 64'(bus.busy), 64'd0);
        chk("abort quot", 64'(bus.quot), 64'd0);
        chk("abort done", 64'(bus.done), 64'd0);
        reset = 1'b1;
        seen  = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done === 1'b1) seen = 1'b1;
        end
        chk("abort no done", 64'(seen), 64'd0);
        run_op("after abort", 32'h40C00000, 32'h40000000, q);
        chk("after abort quot", 64'(q), 64'h40400000);

        // Randomized operands against the reference model.
        for (int i = 0; i < 60; i++) begin
            if (i % 2 == 0) begin
                a = {1'($urandom_range(0, 1)), 8'($urandom_range(90, 164)), 23'($urandom)};
                b = {1'($urandom_range(0, 1)), 8'($urandom_range(90, 164)), 23'($urandom)};
            end else begin
                a = $urandom;
                b = $urandom;
            end
            if ($urandom_range(0, 11) == 0) a = a & 32'h80000000;
            if ($urandom_range(0, 11) == 0) b = b & 32'h80000000;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            run_op("rand", a, b, q);
            chk("rand quot", 64'(q), 64'(ref_div(a, b)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/reflet_float_div.md
# reflet_float_div

Sequential floating-point divider producing `in1 / in2` in the team's float format. It is the inverse companion of the float multiplier in the FPU datapath. It uses a start/done handshake and a fixed-latency restoring division of the significands, one quotient bit per clock. Field widths come from the `reflet_float.vh` functions: `mantissa_size` (M), `exponent_size` (E) and `exponent_bias`.

## Interface
- `float_size`, default 32: total float width; 1 sign bit, E exponent bits, M mantissa bits.
- `clk` input 1: single clock; everything updates on the rising edge.
- `reset` input 1: synchronous, active-low reset.
- `start` input 1: request a division; sampled only in IDLE.
- `in1` input float_size: dividend; captured on the accepted `start` edge.
- `in2` input float_size: divisor; captured on the accepted `start` edge.
- `busy` output 1: high from the edge that accepts `start` until the edge that raises `done`.
- `done` output 1: one-cycle pulse; `quot` is valid from this cycle onward.
- `quot` output float_size: result register; holds its value until the next `done`.
- `div_zero` output 1: present only with `REFLET_FLOAT_DIV_ZERO_FLAG_EN`; see Configuration.

## Operation
- **States:** IDLE, DIVIDE, NORM.
  - IDLE to DIVIDE when `start`=1.
  - DIVIDE to NORM after the iteration counter reaches M+2.
  - NORM to IDLE unconditionally.
- **Load, on the accepted `start` edge:**
  - Dividend significand A = {1, mnt1}, placed in the remainder register (M+2 bits wide).
  - Divisor significand B = {1, mnt2}.
  - Sign = sign1 ^ sign2.
  - Exponent difference is held in a signed E+2-bit register: exp1 - exp2 + bias.
  - Zero flags are captured (magnitude bits [float_size-2:0] equal to 0).
  - Counter cleared.
- **Each DIVIDE cycle (restoring step):**
  - If R >= B: quotient bit = 1 and R = R - B; otherwise quotient bit = 0.
  - Shift the quotient bit into q (M+2 bits).
  - R = R << 1 (the remainder is compared before the shift).
  - Counter increments.
  - After M+2 steps, q = floor(A·2^(M+1) / B).
- **NORM:**
  - If q[M+1]=1: mantissa = q[M:1], exponent = difference.
  - Else: mantissa = q[M-1:0], exponent = difference - 1.
  - The result is truncated; there is no rounding.
- **Specials, resolved in NORM with priority from top to bottom:**
  - in2 magnitude is zero: `quot` = {sign, all-ones exponent, zero mantissa}. This applies even when in1 is zero.
  - in1 magnitude is zero: `quot` = {sign, zeros}.
  - Final exponent <= 0: `quot` = {sign, zeros} (underflow to zero).
  - Final exponent >= all-ones: `quot` = {sign, all-ones exponent, zero mantissa}.
  - Special cases still take the full latency.
- **Other rules:**
  - Input exponents are treated as normal numbers; there is no denormal or NaN handling.
  - `start` while `busy` is ignored, and `in1`/`in2` are not re-sampled.

## Timing
- **Reset values:** `busy`=0, `done`=0, `quot`=0, `div_zero`=0, state IDLE, counter 0.
- **Latency:** `start` is accepted on edge 0. DIVIDE runs on edges 1..M+2. NORM registers `quot` and sets `done`=1 and `busy`=0 on edge M+3. For float_size=32 this is 26 edges.
- **Back-to-back:** `done` lasts one cycle, in IDLE. `start` asserted during that cycle is accepted, so the throughput is one result per M+4 cycles.
- **Reset mid-operation:** `reset`=0 on any edge aborts the operation and applies the reset values. No `done` pulse is emitted.

## Configuration
- **`REFLET_FLOAT_DIV_ZERO_FLAG_EN` defined:**
  - `div_zero` port exists.
  - It is registered in NORM: set to 1 with `done` when in2 magnitude is zero, otherwise 0.
  - It holds its value until the next `done`.
- **Macro undefined:**
  - Port and logic are absent.
  - Divide-by-zero still returns the infinity encoding.

## Test plan
- 0x40C00000 / 0x40000000 (6.0/2.0) → `quot`=0x40400000, `done` exactly 26 edges after `start`, `busy` high for edges 0..25.
- 0x3F800000 / 0x40400000 (1/3) → 0x3EAAAAAA (truncated, normalization-shift path).
- 0xBFC00000 / 0x3F000000 (-1.5/0.5) → 0xC0400000.
- 0x00000000 / 0x40A00000 → 0x00000000. 0x40A00000 / 0x00000000 → 0x7F800000, and `div_zero`=1 when the macro is defined.
- Second `start` with different operands at edge 5 → ignored; the first result appears at edge 26. A `start` during the `done` cycle → accepted, and its result appears 26 edges later.
- `reset`=0 at edge 10 of an operation → `busy`=0, `quot`=0, no `done`. The next operation completes normally.
